// File: rtl/autobuf_steal_arb.sv
// autobuf_steal_arb: autobuffer cycle-steal arbiter for four serial-port channels
// Bit order of all per-channel vectors is {T1,T0,R1,R0}.
module autobuf_steal_arb (
    input  logic        DSPCLK,
    input  logic        RST,
    input  logic        R0req,
    input  logic        R1req,
    input  logic        T0req,
    input  logic        T1req,
    input  logic [3:0]  ABEN,
    input  logic [11:0] ISELcfg,
    input  logic [7:0]  MSELcfg,
    input  logic        STEAL_GNT,
    input  logic        T0wrap,
    input  logic        T1wrap,
    input  logic        R0wrap,
    input  logic        R1wrap,
    input  logic [3:0]  OVFCLR,
    output logic        STEAL_REQ,
    output logic        STEAL_IE1,
    output logic        STEAL_IE2,
    output logic [2:0]  ISEL,
    output logic [1:0]  MSEL,
    output logic        ABRD,
    output logic        ABWR,
    output logic        T0sack,
    output logic        T1sack,
    output logic        R0sack,
    output logic        R1sack,
    output logic [3:0]  ABINT,
    output logic [3:0]  OVF
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_UPD = 2'd2;
    logic [1:0] r_st, w_nst, r_ch, r_msel, w_pri;
    logic [2:0] r_isel;
    logic [3:0] r_pend, r_ovf, r_abint, w_req, w_wrap, w_clr;
    logic       w_grant, w_addr, w_upd;
    assign w_req   = {T1req, T0req, R1req, R0req};
    assign w_wrap  = {T1wrap, T0wrap, R1wrap, R0wrap};
    assign w_addr  = r_st == S_ADDR;
    assign w_upd   = r_st == S_UPD;
    assign w_clr   = w_upd ? 4'b0001 << r_ch : 4'b0000;
    assign w_grant = r_st == S_IDLE && STEAL_GNT && |r_pend;
    assign w_pri   = r_pend[0] ? 2'd0 : r_pend[1] ? 2'd1 : r_pend[2] ? 2'd2 : 2'd3;
    always_ff @(posedge DSPCLK) begin
        if (RST) r_st <= S_IDLE;
        else     r_st <= w_nst;
    end
    always_comb begin
        w_nst = r_st == S_IDLE ? (w_grant ? S_ADDR : S_IDLE) : w_addr ? S_UPD : S_IDLE;
    end
    // A request arriving in its own UPD cycle re-arms pending; OVF set wins over clear.
    always_ff @(posedge DSPCLK) begin
        if (RST) begin
            r_pend  <= '0;
            r_ovf   <= '0;
            r_abint <= '0;
            r_ch    <= '0;
            r_isel  <= '0;
            r_msel  <= '0;
        end else begin
            r_pend  <= ABEN & ((r_pend & ~w_clr) | w_req);
            r_ovf   <= (r_ovf & ~OVFCLR) | (w_req & r_pend & ~w_clr & ABEN);
            r_abint <= w_wrap & ABEN;
            if (w_grant) begin
                r_ch   <= w_pri;
                r_isel <= ISELcfg[3*w_pri +: 3];
                r_msel <= MSELcfg[2*w_pri +: 2];
            end
        end
    end
    always_comb begin
        STEAL_REQ = r_st == S_IDLE && |r_pend;
        STEAL_IE1 = w_addr;
        STEAL_IE2 = w_upd;
        ISEL      = (w_addr || w_upd) ? r_isel : 3'd0;
        MSEL      = (w_addr || w_upd) ? r_msel : 2'd0;
        ABWR      = w_addr && !r_ch[1];
        ABRD      = w_addr && r_ch[1];
        {T1sack, T0sack, R1sack, R0sack} = w_clr;
        ABINT     = r_abint;
        OVF       = r_ovf;
    end
endmodule
